// File: rtl/ammo_resupply.sv
// Reserve-to-magazine reload controller: moves rounds from a reserve stock into
// the weapon magazine in rate-limited, ready/valid handshaked beats.
module ammo_resupply #(
  parameter int N       = 9,
  parameter int MAG_MAX = 500
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   mode_selector,
  input  logic         fire,
  input  logic         reload_req,
  input  logic         reserve_load,
  input  logic [N-1:0] reserve_in,
  input  logic [N-1:0] mag_level,
  input  logic [N-1:0] xfer_rate,
  input  logic         xfer_ready,
  output logic         xfer_valid,
  output logic [N-1:0] xfer_amount,
  output logic [N-1:0] reserve,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [3:0]   ATTACK  = 4'b0010;
  localparam logic [N-1:0] MAG_CAP = N'(MAG_MAX);

  // Rounds missing from the magazine; a reading at or above capacity means full.
  function automatic logic [N-1:0] sat_need(input logic [N-1:0] lvl);
    return (lvl >= MAG_CAP) ? '0 : MAG_CAP - lvl;
  endfunction

  function automatic logic [N-1:0] min3(input logic [N-1:0] a,
                                        input logic [N-1:0] b,
                                        input logic [N-1:0] c);
    logic [N-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  state_t       state, state_nxt;
  logic [N-1:0] need, rate_q, reserve_q;
  logic         err_q;
  logic [N-1:0] amt;
  logic [N-1:0] entry_need;
  logic         blocked, grant, entry_ok;

  assign blocked    = fire | (mode_selector == ATTACK);
  assign grant      = (state == IDLE) & reload_req & ~blocked;
  assign entry_need = sat_need(mag_level);
  // Entry checks look at the reserve as it was before any coinciding load.
  assign entry_ok   = (reserve_q != '0) && (xfer_rate != '0);
  assign amt        = min3(rate_q, need, reserve_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant) begin
          if (entry_need == '0) state_nxt = DONE;
          else if (entry_ok)    state_nxt = XFER;
        end
      end
      XFER: begin
        if (blocked)
          state_nxt = IDLE;
        else if (xfer_ready && ((need == amt) || (reserve_q == amt)))
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reserve_q <= '0;
      need      <= '0;
      rate_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (reserve_load) reserve_q <= reserve_in;
          if (reload_req) begin
            if (blocked) begin
              err_q <= 1'b1;
            end else begin
              rate_q <= xfer_rate;
              need   <= entry_need;
              if ((entry_need != '0) && !entry_ok) err_q <= 1'b1;
            end
          end
        end
        XFER: begin
          // An abort wins over a beat accepted on the same edge.
          if (blocked) begin
            err_q <= 1'b1;
          end else if (xfer_ready) begin
            need      <= need - amt;
            reserve_q <= reserve_q - amt;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    xfer_valid  = 1'b0;
    xfer_amount = '0;
    busy        = (state != IDLE);
    done        = 1'b0;
    error       = err_q;
    case (state)
      XFER: begin
        xfer_valid  = 1'b1;
        xfer_amount = amt;
      end
      DONE: begin
        done  = 1'b1;
        error = err_q | (need != '0);
      end
      default: ;
    endcase
  end

  assign reserve = reserve_q;

endmodule

// File: tb/tb_ammo_resupply.sv
// Scoreboard bench for ammo_resupply: a transaction-level model predicts beats and
// completion events; a negedge monitor matches what the DUT presents.
module tb_ammo_resupply;

  localparam int N       = 9;
  localparam int MAG_MAX = 500;
  localparam logic [3:0] ATTACK = 4'b0010;
  localparam int K_BEAT = 0, K_DONE = 1, K_ERR = 2;

  logic         clk, rst;
  logic [3:0]   mode_selector;
  logic         fire, reload_req, reserve_load, xfer_ready;
  logic [N-1:0] reserve_in, mag_level, xfer_rate;
  logic         xfer_valid, busy, done, error;
  logic [N-1:0] xfer_amount, reserve;

  ammo_resupply #(.N(N), .MAG_MAX(MAG_MAX)) dut (
    .clk(clk), .rst(rst), .mode_selector(mode_selector), .fire(fire),
    .reload_req(reload_req), .reserve_load(reserve_load), .reserve_in(reserve_in),
    .mag_level(mag_level), .xfer_rate(xfer_rate), .xfer_ready(xfer_ready),
    .xfer_valid(xfer_valid), .xfer_amount(xfer_amount), .reserve(reserve),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int amt;
    int err;
    int res;
  } item_t;

  item_t q[$];
  item_t mon_it;
  int    checks = 0;
  int    failures = 0;
  int    m_res = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input int k, input int a, input int e, input int r);
    item_t it;
    it.kind = k; it.amt = a; it.err = e; it.res = r;
    q.push_back(it);
  endfunction

  function automatic logic [3:0] safe_mode();
    case ($urandom_range(2))
      0:       return 4'b0001;
      1:       return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // Reference: walk the whole reload with plain integers and queue every event.
  task automatic model_op(input bit ld, input int ldv, input int lvl, input int rate,
                          input bit refuse, input int abort_after);
    int need, res, old, amt, k;
    old  = m_res;
    res  = ld ? ldv : old;
    need = (lvl >= MAG_MAX) ? 0 : MAG_MAX - lvl;
    if (refuse) push(K_ERR, 0, 0, res);
    else if (need == 0) push(K_DONE, 0, 0, res);
    else if (old == 0 || rate == 0) push(K_ERR, 0, 0, res);
    else begin
      k = 0;
      while (1) begin
        amt = rate;
        if (need < amt) amt = need;
        if (res < amt)  amt = res;
        if (abort_after >= 0 && k == abort_after) begin
          push(K_ERR, 0, 0, res);
          break;
        end
        push(K_BEAT, amt, 0, res);
        need -= amt;
        res  -= amt;
        k++;
        if (need == 0 || res == 0) begin
          push(K_DONE, 0, (need != 0) ? 1 : 0, res);
          break;
        end
      end
    end
    m_res = res;
  endtask

  task automatic load_res(input int v);
    @(posedge clk); #2;
    reload_req = 1'b0; reserve_load = 1'b1; reserve_in = N'(v);
    @(posedge clk); #2;
    reserve_load = 1'b0;
    m_res = v;
    chk("load_reserve", int'(reserve), m_res);
  endtask

  task automatic drive_op(input bit ld, input int ldv, input int lvl, input int rate,
                          input bit use_fire, input bit use_attack, input int abort_after,
                          input bit abort_mode, input int stall_pct, input int stall_beat);
    int beats, stall_cnt;
    bit stalled, pv, pr, pa, finished;
    beats = 0; stall_cnt = 0; stalled = 0; pv = 0; pr = 0; pa = 0; finished = 0;
    @(posedge clk); #2;
    reload_req = 1'b1; reserve_load = ld; reserve_in = N'(ldv);
    mag_level = N'(lvl); xfer_rate = N'(rate); fire = use_fire;
    mode_selector = use_attack ? ATTACK : safe_mode();
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(posedge clk); #2;
      if (pv && pr && !pa) beats++;
      reload_req = 1'b0; reserve_load = 1'b0; fire = 1'b0;
      mode_selector = safe_mode();
      pa = 1'b0;
      if (!busy) finished = 1'b1;
      else begin
        // Disturbances the controller must ignore while busy.
        mag_level    = N'($urandom);
        reserve_load = ($urandom_range(3) == 0);
        reserve_in   = N'($urandom);
        if (xfer_valid && abort_after >= 0 && beats == abort_after) begin
          if (abort_mode) mode_selector = ATTACK;
          else            fire = 1'b1;
          pa = 1'b1;
        end
        if (stall_cnt > 0) begin
          xfer_ready = 1'b0;
          stall_cnt--;
        end else if (!stalled && stall_beat >= 0 && beats == stall_beat && xfer_valid) begin
          stalled = 1'b1; stall_cnt = 4; xfer_ready = 1'b0;
        end else begin
          xfer_ready = ($urandom_range(99) >= stall_pct);
        end
      end
      pv = xfer_valid; pr = xfer_ready;
    end
    if (!finished) chk("op_timeout", 0, 1);
    repeat (2) begin
      @(posedge clk); #2;
      xfer_ready = $urandom_range(1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (xfer_valid) begin
        chk("busy_in_xfer", busy, 1);
        if (q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          mon_it = q[0];
          if (fire || mode_selector == ATTACK) chk("abort_expected", mon_it.kind, K_ERR);
          else begin
            chk("beat_kind", mon_it.kind, K_BEAT);
            chk("beat_amount", int'(xfer_amount), mon_it.amt);
            chk("beat_reserve", int'(reserve), mon_it.res);
            if (xfer_ready) void'(q.pop_front());
          end
        end
      end
      if (done || error) begin
        if (q.size() == 0) chk("event_unexpected", 1, 0);
        else begin
          mon_it = q.pop_front();
          if (done) begin
            chk("done_kind", mon_it.kind, K_DONE);
            chk("done_error", error, mon_it.err);
          end else begin
            chk("err_kind", mon_it.kind, K_ERR);
            chk("err_busy", busy, 0);
          end
          chk("end_reserve", int'(reserve), mon_it.res);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    mode_selector = 4'b0001; fire = 1'b0; reload_req = 1'b0; reserve_load = 1'b0;
    reserve_in = '0; mag_level = '0; xfer_rate = '0; xfer_ready = 1'b0;
    #1;
    chk("reset_valid", xfer_valid, 0);
    chk("reset_reserve", int'(reserve), 0);
    chk("reset_busy", busy, 0);
    chk("reset_done_error", {done, error}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Normal reload: 8, 8, 4 then done with 180 left.
    load_res(200);
    model_op(0, 0, 480, 8, 0, -1);
    drive_op(0, 0, 480, 8, 0, 0, -1, 0, 0, -1);

    // Short reload: reserve runs dry, done and error together.
    load_res(10);
    model_op(0, 0, 0, 4, 0, -1);
    drive_op(0, 0, 0, 4, 0, 0, -1, 0, 0, -1);

    // Five-cycle stall after the first beat.
    load_res(200);
    model_op(0, 0, 0, 8, 0, -1);
    drive_op(0, 0, 0, 8, 0, 0, -1, 0, 0, 1);

    // Abort by fire after one beat.
    load_res(200);
    model_op(0, 0, 0, 8, 0, 1);
    drive_op(0, 0, 0, 8, 0, 0, 1, 0, 0, -1);

    // Refusals and edge cases.
    model_op(0, 0, 0, 8, 1, -1);
    drive_op(0, 0, 0, 8, 0, 1, -1, 0, 0, -1);
    model_op(0, 0, 500, 8, 0, -1);
    drive_op(0, 0, 500, 8, 0, 0, -1, 0, 0, -1);
    model_op(0, 0, 100, 0, 0, -1);
    drive_op(0, 0, 100, 0, 0, 0, -1, 0, 0, -1);
    load_res(0);
    model_op(0, 0, 100, 8, 0, -1);
    drive_op(0, 0, 100, 8, 0, 0, -1, 0, 0, -1);
    model_op(1, 50, 100, 8, 0, -1);
    drive_op(1, 50, 100, 8, 0, 0, -1, 0, 0, -1);
    model_op(0, 0, 10, 8, 1, -1);
    drive_op(0, 0, 10, 8, 1, 0, -1, 0, 0, -1);

    // Asynchronous reset in the middle of a transfer.
    load_res(200);
    model_op(0, 0, 0, 8, 0, -1);
    @(posedge clk); #2;
    reload_req = 1'b1; mag_level = '0; xfer_rate = N'(8); fire = 1'b0;
    mode_selector = safe_mode(); xfer_ready = 1'b0;
    @(posedge clk); #2;
    reload_req = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_valid", xfer_valid, 0);
    chk("midrst_amount", int'(xfer_amount), 0);
    chk("midrst_reserve", int'(reserve), 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done_error", {done, error}, 0);
    q.delete();
    m_res = 0;
    @(posedge clk); #2 rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      int ldv, lvl, rate, ab;
      bit ld, rf, ra, amode;
      if ($urandom_range(2) == 0) load_res($urandom_range(511));
      ld    = ($urandom_range(4) == 0);
      ldv   = $urandom_range(511, 1);
      lvl   = $urandom_range(511);
      rate  = ($urandom_range(9) == 0) ? 0 : $urandom_range(64, 1);
      rf    = ($urandom_range(14) == 0);
      ra    = ($urandom_range(14) == 0);
      ab    = ($urandom_range(4) == 0) ? $urandom_range(3) : -1;
      amode = $urandom_range(1);
      model_op(ld, ldv, lvl, rate, rf || ra, ab);
      drive_op(ld, ldv, lvl, rate, rf, ra, ab, amode, 30, -1);
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ammo_resupply.md
AMMO_RESUPPLY -- requirements
Module: ammo_resupply

Interface
REQ-001 Parameter N, default 9: width of all count datapaths.
REQ-002 Parameter MAG_MAX, default 500: magazine capacity in rounds (must be < 2^N).
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 mode_selector  input  4  one-hot ship mode; 4'b0010 = attack mode.
REQ-006 fire  input  1  weapon trigger, level-sensitive.
REQ-007 reload_req  input  1  request to refill magazine; sampled only in IDLE.
REQ-008 reserve_load  input  1  load reserve_in into reserve stock; honoured only in IDLE.
REQ-009 reserve_in  input  N  rounds to load into the reserve.
REQ-010 mag_level  input  N  current magazine count from the weapon counter.
REQ-011 xfer_rate  input  N  maximum rounds per transfer beat.
REQ-012 xfer_ready  input  1  weapon side accepts the current beat.
REQ-013 xfer_valid  output  1  a transfer beat is offered.
REQ-014 xfer_amount  output  N  rounds in the offered beat.
REQ-015 reserve  output  N  current reserve stock.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse when a reload completes.
REQ-018 error  output  1  one-cycle pulse on a refused, aborted or short reload.

Function
REQ-019 The FSM SHALL have states IDLE, XFER and DONE; DONE lasts exactly one cycle and then returns to IDLE.
REQ-020 IDLE entry rule: reload_req=1, fire=0 and mode_selector!=4'b0010 at a clock edge -> latch rate_q<=xfer_rate and need<=MAG_MAX-mag_level, saturated to 0 when mag_level>=MAG_MAX.
REQ-021 Zero need: if the latched need is 0, the FSM SHALL go directly to DONE with no beats.
REQ-022 Empty reserve or zero rate: if reserve==0 or xfer_rate==0 at entry, the FSM SHALL stay in IDLE and pulse error the next cycle.
REQ-023 Otherwise the FSM SHALL go to XFER on that edge.
REQ-024 Refused request: reload_req while fire=1 or mode_selector==4'b0010 SHALL pulse error one cycle later and leave the FSM in IDLE.
REQ-025 In XFER, xfer_valid SHALL be 1 and xfer_amount SHALL equal min(rate_q, need, reserve).
REQ-026 xfer_amount SHALL be stable while xfer_valid=1 and xfer_ready=0; need, reserve and rate_q change only on an accepted beat.
REQ-027 Accepted beat (xfer_valid & xfer_ready): need-=xfer_amount and reserve-=xfer_amount on the same edge; neither underflows.
REQ-028 After an accepted beat, if need reaches 0 or reserve reaches 0, the FSM SHALL move to DONE; otherwise it remains in XFER.
REQ-029 In DONE, done SHALL be 1. If need!=0 (short because the reserve emptied), error SHALL also be 1 in that same cycle.
REQ-030 Abort: fire=1 or mode_selector==4'b0010 while in XFER SHALL, on that edge, return the FSM to IDLE, drop xfer_valid, pulse error next cycle and keep reserve as is; an abort outranks a simultaneous accepted beat, which is discarded.
REQ-031 reserve_load in IDLE SHALL set reserve<=reserve_in; if it coincides with a granted reload_req, the load takes effect and the entry checks use the old reserve.
REQ-032 reserve_load outside IDLE SHALL be ignored.
REQ-033 mag_level changes during XFER SHALL NOT alter the latched need.

Reset
REQ-034 While rst=1, asynchronously: state=IDLE; reserve, need, rate_q=0; xfer_valid, done, error, busy=0; xfer_amount=0.
REQ-035 Reset asserted mid-XFER SHALL discard the transfer, with no done or error pulse.

Verification
REQ-036 Reset: assert rst mid-XFER -> all outputs 0 and reserve=0 immediately, before the next clk edge.
REQ-037 Normal reload: reserve_load 200, mag_level=480, xfer_rate=8, xfer_ready=1 -> beats of 8, 8, 4; then done pulse; reserve=180; error=0.
REQ-038 Short reload: reserve=10, mag_level=0, xfer_rate=4 -> beats of 4, 4, 2; reserve=0; done and error pulse in the same cycle.
REQ-039 Stall: xfer_ready=0 for 5 cycles mid-XFER -> xfer_valid=1 and xfer_amount unchanged throughout; need and reserve unchanged.
REQ-040 Abort: fire=1 after first accepted beat (amount 8, reserve 200) -> IDLE, xfer_valid=0, error pulse, reserve=192, no done.
REQ-041 Refusal: reload_req with mode_selector=4'b0010 -> error pulse, busy stays 0; reload_req with mag_level=500 -> done pulse with no beats.
